jtag_tap_slave: RTL and testbench

//  IEEE 1149.1-style TAP slave on the slave side of the JTAG bus (tdi/tms in, tdo out).

---
 rtl/jtag_pkg.sv | 44 ++++
 rtl/jtag_tap_fsm.sv | 47 ++++
 rtl/jtag_tap_slave.sv | 140 ++++++++++++++
 tb/tb_jtag_tap_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP slave.
// Contents:
//   IR_W          instruction register width
//   IR_IDCODE     opcode selecting the IDCODE data register
//   IR_USER       opcode selecting the USER scratch data register
//   IR_BYPASS     opcode selecting the 1-bit BYPASS register
//   IR_CAPTURE    value loaded into the IR shift register in CAP_IR
//   tap_state_e   16 TAP controller states, standard 1149.1 4-bit encoding
//   dr_sel_e      data register selected by the current instruction
package jtag_pkg;

    localparam int IR_W = 4;

    localparam logic [IR_W-1:0] IR_IDCODE  = 4'b0001;
    localparam logic [IR_W-1:0] IR_USER    = 4'b0010;
    localparam logic [IR_W-1:0] IR_BYPASS  = 4'b1111;
    localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR  = 4'h0,
        TAP_EXIT1_DR  = 4'h1,
        TAP_SHIFT_DR  = 4'h2,
        TAP_PAUSE_DR  = 4'h3,
        TAP_SEL_IR    = 4'h4,
        TAP_UPDATE_DR = 4'h5,
        TAP_CAP_DR    = 4'h6,
        TAP_SEL_DR    = 4'h7,
        TAP_EXIT2_IR  = 4'h8,
        TAP_EXIT1_IR  = 4'h9,
        TAP_SHIFT_IR  = 4'hA,
        TAP_PAUSE_IR  = 4'hB,
        TAP_RTI       = 4'hC,
        TAP_UPDATE_IR = 4'hD,
        TAP_CAP_IR    = 4'hE,
        TAP_TLR       = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_SEL_IDCODE = 2'd0,
        DR_SEL_USER   = 2'd1,
        DR_SEL_BYPASS = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine: state register plus next-state decode.
// Ports:
//   tck    in   clock, all updates on posedge
//   trst   in   synchronous active-high reset to TEST_LOGIC_RESET
//   tms    in   mode select steering the state transitions
//   state  out  current TAP state (registered)
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_r;

    // TAP state register; reset overrides tms
    always_ff @(posedge tck) begin
        if (trst) begin
            state_r <= TAP_TLR;
        end else begin
            case (state_r)
                TAP_TLR:       state_r <= tms ? TAP_TLR       : TAP_RTI;
                TAP_RTI:       state_r <= tms ? TAP_SEL_DR    : TAP_RTI;
                TAP_SEL_DR:    state_r <= tms ? TAP_SEL_IR    : TAP_CAP_DR;
                TAP_CAP_DR:    state_r <= tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
                TAP_SHIFT_DR:  state_r <= tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
                TAP_EXIT1_DR:  state_r <= tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR:  state_r <= tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
                TAP_EXIT2_DR:  state_r <= tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
                TAP_UPDATE_DR: state_r <= tms ? TAP_SEL_DR    : TAP_RTI;
                TAP_SEL_IR:    state_r <= tms ? TAP_TLR       : TAP_CAP_IR;
                TAP_CAP_IR:    state_r <= tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
                TAP_SHIFT_IR:  state_r <= tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
                TAP_EXIT1_IR:  state_r <= tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR:  state_r <= tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
                TAP_EXIT2_IR:  state_r <= tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
                TAP_UPDATE_IR: state_r <= tms ? TAP_SEL_DR    : TAP_RTI;
                default:       state_r <= TAP_TLR;
            endcase
        end
    end

    assign state = state_r;

endmodule

// File: rtl/jtag_tap_slave.sv
// JTAG TAP slave with a 4-bit IR and IDCODE / BYPASS / USER data registers.
// Ports:
//   tck   in   clock, all state updates on posedge
//   trst  in   synchronous active-high reset
//   tdi   in   serial data in, sampled on posedge
//   tms   in   mode select, sampled on posedge
//   tdo   out  LSB of the active shift register while shifting, else 0
// Parameters:
//   USER_W      width of the USER scratch register
//   IDCODE_VAL  value captured for IDCODE (bit0 must be 1)
module jtag_tap_slave
    import jtag_pkg::*;
#(
    parameter int          USER_W     = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
    input  logic tck,
    input  logic trst,
    input  logic tdi,
    input  logic tms,
    output logic tdo
);

    // One physical shift register serves every DR; it must hold the longest chain.
    localparam int DR_W   = (USER_W > 32) ? USER_W : 32;
    localparam int ID_LEN = 32;

    tap_state_e        state_s;
    dr_sel_e           dr_sel_s;
    int                chain_len_s;
    logic [IR_W-1:0]   ir_r, ir_next_s;
    logic [IR_W-1:0]   ir_sr_r, ir_sr_next_s;
    logic [DR_W-1:0]   dr_sr_r, dr_sr_next_s;
    logic [USER_W-1:0] user_reg_r, user_next_s;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (state_s)
    );

    // Shift right over the low len bits only; tdi lands at bit len-1, upper bits hold.
    function automatic logic [DR_W-1:0] shift_chain(input logic [DR_W-1:0] cur,
                                                    input logic din, input int len);
        logic [DR_W:0]   cur_ext;
        logic [DR_W-1:0] res;
        cur_ext = {1'b0, cur};
        res     = cur;
        for (int i = 0; i < DR_W; i++) begin
            if (i == len - 1) begin
                res[i] = din;
            end else if (i < len - 1) begin
                res[i] = cur_ext[i+1];
            end else begin
                res[i] = cur[i];
            end
        end
        return res;
    endfunction

    // Instruction decode: unknown opcodes fall back to BYPASS
    always_comb begin
        dr_sel_s    = DR_SEL_BYPASS;
        chain_len_s = 1;
        case (ir_r)
            IR_IDCODE: begin
                dr_sel_s    = DR_SEL_IDCODE;
                chain_len_s = ID_LEN;
            end
            IR_USER: begin
                dr_sel_s    = DR_SEL_USER;
                chain_len_s = USER_W;
            end
            default: begin
                dr_sel_s    = DR_SEL_BYPASS;
                chain_len_s = 1;
            end
        endcase
    end

    // Next-value decode for IR, IR/DR shift registers and USER register
    always_comb begin
        ir_next_s    = ir_r;
        ir_sr_next_s = ir_sr_r;
        dr_sr_next_s = dr_sr_r;
        user_next_s  = user_reg_r;
        case (state_s)
            // TLR is entered by tms only from TLR itself or SEL_IR
            TAP_TLR, TAP_SEL_IR: begin
                if (tms) begin
                    ir_next_s = IR_IDCODE;
                end else begin
                    ir_next_s = ir_r;
                end
            end
            TAP_CAP_IR:    ir_sr_next_s = IR_CAPTURE;
            TAP_SHIFT_IR:  ir_sr_next_s = {tdi, ir_sr_r[IR_W-1:1]};
            TAP_UPDATE_IR: ir_next_s    = ir_sr_r;
            TAP_CAP_DR: begin
                dr_sr_next_s = '0;
                case (dr_sel_s)
                    DR_SEL_IDCODE: dr_sr_next_s[31:0]       = IDCODE_VAL;
                    DR_SEL_USER:   dr_sr_next_s[USER_W-1:0] = user_reg_r;
                    default:       dr_sr_next_s             = '0;
                endcase
            end
            TAP_SHIFT_DR: dr_sr_next_s = shift_chain(dr_sr_r, tdi, chain_len_s);
            TAP_UPDATE_DR: begin
                if (dr_sel_s == DR_SEL_USER) begin
                    user_next_s = dr_sr_r[USER_W-1:0];
                end else begin
                    user_next_s = user_reg_r;
                end
            end
            // Pause, exit, select-DR and RTI hold every register
            default: ir_next_s = ir_r;
        endcase
    end

    // IR, shift and USER registers with synchronous reset
    always_ff @(posedge tck) begin
        if (trst) begin
            ir_r       <= IR_IDCODE;
            ir_sr_r    <= '0;
            dr_sr_r    <= '0;
            user_reg_r <= '0;
        end else begin
            ir_r       <= ir_next_s;
            ir_sr_r    <= ir_sr_next_s;
            dr_sr_r    <= dr_sr_next_s;
            user_reg_r <= user_next_s;
        end
    end

    // tdo shows the bit about to be shifted out, so the master's posedge sample gets the LSB first
    assign tdo = (state_s == TAP_SHIFT_IR) ? ir_sr_r[0] :
                 (state_s == TAP_SHIFT_DR) ? dr_sr_r[0] : 1'b0;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Directed self-checking bench for jtag_tap_slave.
module tb_jtag_tap_slave;
    import jtag_pkg::*;

    logic tck = 1'b0;
    logic trst;
    logic tdi;
    logic tms;
    logic tdo;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_tap_slave dut (
        .tck  (tck),
        .trst (trst),
        .tdi  (tdi),
        .tms  (tms),
        .tdo  (tdo)
    );

    always #5 tck = ~tck;

    // Drive tms/tdi on negedge, capture tdo before the posedge that consumes them
    task automatic step(input logic t_ms, input logic t_di, output logic t_do);
        @(negedge tck);
        tms = t_ms;
        tdi = t_di;
        #1 t_do = tdo;
        @(posedge tck);
        #1;
    endtask

    // From SHIFT_x: shift n bits LSB-first, optionally leaving to EXIT1 on the last one
    task automatic shift_bits(input logic [31:0] din, input int n, input logic exit_last,
                              output logic [31:0] dout);
        logic b;
        dout = 32'd0;
        for (int i = 0; i < n; i++) begin
            step(exit_last && (i == n - 1), din[i], b);
            dout[i] = b;
        end
    endtask

    // RTI -> SHIFT_DR
    task automatic goto_shift_dr();
        logic b;
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    // EXIT1 -> UPDATE -> RTI
    task automatic exit_update();
        logic b;
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    // RTI -> shift a new instruction -> RTI; returns the captured IR bits
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
        logic b;
        logic [31:0] d;
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        shift_bits({28'd0, val}, 4, 1'b1, d);
        cap = d[3:0];
        exit_update();
    endtask

    task automatic test_reset();
        @(negedge tck);
        trst = 1'b1;
        tms  = 1'b0;
        tdi  = 1'b0;
        @(posedge tck);
        @(posedge tck);
        #1;
        n_checks++;
        if (dut.state_s !== TAP_TLR) begin
            n_fail++;
            $display("FAIL reset_state: got %0h expected %0h", dut.state_s, TAP_TLR);
        end
        n_checks++;
        if (dut.ir_r !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ir: got %b expected 0001", dut.ir_r);
        end
        n_checks++;
        if (dut.user_reg_r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_user: got %h expected 00000000", dut.user_reg_r);
        end
        n_checks++;
        if (tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tdo: got %b expected 0", tdo);
        end
        @(negedge tck);
        trst = 1'b0;
    endtask

    task automatic test_idcode();
        logic b;
        logic [31:0] d;
        step(1'b0, 1'b0, b);
        goto_shift_dr();
        shift_bits(32'd0, 32, 1'b1, d);
        n_checks++;
        if (d !== 32'h1234_5679) begin
            n_fail++;
            $display("FAIL idcode_read: got %h expected 12345679", d);
        end
        exit_update();
    endtask

    task automatic test_tms_reset();
        logic b;
        logic [3:0] cap;
        logic [5:0] path_bits [16];
        int         path_len  [16];
        tap_state_e path_st   [16];
        path_bits = '{6'b000111, 6'b000000, 6'b000001, 6'b000001, 6'b000001, 6'b000101,
                      6'b000101, 6'b010101, 6'b001101, 6'b000011, 6'b000011, 6'b000011,
                      6'b001011, 6'b001011, 6'b101011, 6'b011011};
        path_len  = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
        path_st   = '{TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
                      TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPDATE_DR, TAP_SEL_IR, TAP_CAP_IR,
                      TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPDATE_IR};
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 5; j++) step(1'b1, 1'b0, b);
            step(1'b0, 1'b0, b);
            load_ir(IR_USER, cap);
            for (int j = 0; j < path_len[k]; j++) step(path_bits[k][j], 1'b0, b);
            n_checks++;
            if (dut.state_s !== path_st[k]) begin
                n_fail++;
                $display("FAIL tms_nav[%0d]: got %0h expected %0h", k, dut.state_s, path_st[k]);
            end
            for (int j = 0; j < 5; j++) step(1'b1, 1'b0, b);
            n_checks++;
            if (dut.state_s !== TAP_TLR) begin
                n_fail++;
                $display("FAIL tms5_state[%0d]: got %0h expected %0h", k, dut.state_s, TAP_TLR);
            end
            n_checks++;
            if (dut.ir_r !== 4'b0001) begin
                n_fail++;
                $display("FAIL tms5_ir[%0d]: got %b expected 0001", k, dut.ir_r);
            end
        end
        step(1'b0, 1'b0, b);
    endtask

    task automatic test_bypass(input logic [3:0] op);
        logic [3:0]  cap;
        logic [31:0] d;
        load_ir(op, cap);
        n_checks++;
        if (cap !== 4'b0001) begin
            n_fail++;
            $display("FAIL ir_capture[%b]: got %b expected 0001", op, cap);
        end
        n_checks++;
        if (dut.ir_r !== op) begin
            n_fail++;
            $display("FAIL ir_update[%b]: got %b expected %b", op, dut.ir_r, op);
        end
        goto_shift_dr();
        shift_bits(32'h0000_000D, 4, 1'b1, d);
        n_checks++;
        if (d[3:0] !== 4'b1010) begin
            n_fail++;
            $display("FAIL bypass_tdo[%b]: got %b expected 1010", op, d[3:0]);
        end
        exit_update();
    endtask

    task automatic test_user_rw();
        logic [3:0]  cap;
        logic [31:0] d;
        load_ir(IR_USER, cap);
        goto_shift_dr();
        shift_bits(32'hDEAD_BEEF, 32, 1'b1, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL user_initial: got %h expected 00000000", d);
        end
        exit_update();
        n_checks++;
        if (dut.user_reg_r !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL user_write: got %h expected deadbeef", dut.user_reg_r);
        end
        goto_shift_dr();
        shift_bits(32'd0, 32, 1'b1, d);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL user_readback: got %h expected deadbeef", d);
        end
        exit_update();
    endtask

    task automatic test_pause();
        logic b;
        logic [31:0] d;
        logic [31:0] pat;
        pat = 32'hA5C3_0F96;
        goto_shift_dr();
        shift_bits(pat, 16, 1'b1, d);
        n_checks++;
        if (d[15:0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL pause_first_half: got %h expected 0000", d[15:0]);
        end
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        n_checks++;
        if (dut.state_s !== TAP_PAUSE_DR || tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold: got state %0h tdo %b expected %0h tdo 0",
                     dut.state_s, tdo, TAP_PAUSE_DR);
        end
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        shift_bits(pat >> 16, 16, 1'b1, d);
        exit_update();
        n_checks++;
        if (dut.user_reg_r !== pat) begin
            n_fail++;
            $display("FAIL pause_resume: got %h expected %h", dut.user_reg_r, pat);
        end
    endtask

    task automatic test_trst_mid_shift();
        logic [31:0] d;
        goto_shift_dr();
        shift_bits(32'hFFFF_FFFF, 10, 1'b0, d);
        n_checks++;
        if (dut.state_s !== TAP_SHIFT_DR) begin
            n_fail++;
            $display("FAIL trst_pre_state: got %0h expected %0h", dut.state_s, TAP_SHIFT_DR);
        end
        @(negedge tck);
        trst = 1'b1;
        tms  = 1'b0;
        @(posedge tck);
        #1;
        n_checks++;
        if (dut.user_reg_r !== 32'd0) begin
            n_fail++;
            $display("FAIL trst_user: got %h expected 00000000", dut.user_reg_r);
        end
        n_checks++;
        if (dut.state_s !== TAP_TLR) begin
            n_fail++;
            $display("FAIL trst_state: got %0h expected %0h", dut.state_s, TAP_TLR);
        end
        n_checks++;
        if (dut.ir_r !== 4'b0001) begin
            n_fail++;
            $display("FAIL trst_ir: got %b expected 0001", dut.ir_r);
        end
        n_checks++;
        if (tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL trst_tdo: got %b expected 0", tdo);
        end
        @(negedge tck);
        trst = 1'b0;
    endtask

    initial begin
        trst = 1'b0;
        tms  = 1'b1;
        tdi  = 1'b0;
        test_reset();
        test_idcode();
        test_tms_reset();
        test_bypass(IR_BYPASS);
        test_bypass(4'b0101);
        test_user_rw();
        test_pause();
        test_trst_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
